fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline: owns the PC, drives the instruction-memory request handshake, and produces the IF/ID pipeline register consumed by the decode stage and the hazard-detection unit. It honours load-use stalls from hazard detection and redirects (taken branch/jump) resolved in ID. It tolerates multi-cycle instruction memory by inserting bubbles into IF/ID while a fetch is outstanding.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded at reset
- NOP_INST, 32'h0000_0000, instruction word placed in IF/ID on bubble/flush
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous, active-low reset
- start_i  in  1  fetch enable; sampled only in IDLE
- pc_stall_i  in  1  hold PC (from hazard detection)
- stall_hold_i  in  1  hold IF/ID (from hazard detection); stall = pc_stall_i | stall_hold_i
- redirect_i  in  1  taken branch/jump resolved in ID this cycle
- redirect_pc_i  in  32  redirect target; bits [1:0] forced to 0
- imem_req_o  out  1  fetch request
- imem_addr_o  out  32  fetch address, stable while imem_req_o high
- imem_ready_i  in  1  data valid this cycle; ignored when imem_req_o low
- imem_data_i  in  32  instruction word, valid with imem_ready_i
- pc_o  out  32  next-fetch PC (debug/trace)
- if_id_pc_o  out  32  PC+4 of instruction in IF/ID
- if_id_inst_o  out  32  instruction in IF/ID (feeds hazard detection)
- if_id_valid_o  out  1  IF/ID holds a real instruction

## Operation
- Reset: state IDLE, pc_q=addr_q=RESET_PC, imem_req_o=0, if_id_pc_o=0, if_id_inst_o=NOP_INST, if_id_valid_o=0, skid buffer empty.
- IF/ID update each edge: redirect -> bubble (flush wins over stall); else stall -> hold; else load fetched word (valid=1) if one delivered this cycle, otherwise bubble.
- IDLE: req=0; start_i=1 -> REQ, addr_q=pc_q.
- REQ: req=1, addr=addr_q(=pc_q).
  - ready & redirect: discard word; pc_q=addr_q=target; stay REQ.
  - ready & stall: word into skid buffer; -> HOLD; pc_q unchanged.
  - ready, else: IF/ID <= {pc_q+4, data, 1}; pc_q=addr_q=pc_q+4; stay REQ.
  - no ready & redirect: pc_q=target; addr_q held; -> DROP.
- HOLD: req=0. Redirect -> discard buffer, pc_q=addr_q=target, -> REQ. Stall low -> IF/ID <= {pc_q+4, buffer, 1}, pc_q=addr_q=pc_q+4, -> REQ.
- DROP: req=1 at old addr_q (request never aborted). Further redirect updates pc_q only. On ready: discard word, addr_q=pc_q, -> REQ.
- PC arithmetic 32-bit modulo: 32'hFFFF_FFFC+4 = 0.
- start_i ignored outside IDLE; no return to IDLE except reset.

## Timing
- Zero-wait memory (ready in first REQ cycle): 1 instruction/cycle, word in IF/ID the edge after ready.
- N-cycle memory: N-1 bubbles then the word; request held with stable address until ready.
- Redirect: first target-path request issued the cycle after redirect (REQ) or after old request completes (DROP).
- Stall release from HOLD: buffered word enters IF/ID on the release edge, no extra memory access.
- Reset mid-request: req drops asynchronously; memory must tolerate abandoned request.

## Structure
- Package fetch_pkg: state enum {IDLE, REQ, HOLD, DROP}, NOP_INST, RESET_PC default, 32-bit word width constant.
- One sub-module: if_id_reg (pc/inst/valid register with hold and flush inputs, async active-low reset).

## Test plan
- Reset, start_i=1, zero-wait memory returning addr as data -> IF/ID sequence {4,0},{8,4},{12,8}, valid every cycle.
- 3-cycle memory -> imem_addr_o stable 3 cycles, 2 bubbles (valid=0) then {4,inst}.
- pc_stall_i=stall_hold_i=1 for 2 cycles while ready arrives -> IF/ID held, state HOLD, buffered word appears on release, PC advances once.
- redirect_i with target 32'h100 while request at 0x8 pending -> DROP, 0x8 word discarded, next request addr 0x100, IF/ID bubble.
- redirect and stall same cycle -> IF/ID flushed (NOP_INST, valid=0), pc_o=target.
- rst_i low mid-DROP -> all outputs to reset values immediately, fetch resumes at RESET_PC after start_i.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   state_t          fetch FSM states (IDLE, REQ, HOLD, DROP)
//   WORD_W           instruction / address word width
//   NOP_INST         instruction word placed in IF/ID on bubble or flush
//   RESET_PC_DEFAULT default PC loaded at reset
package fetch_pkg;
    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] NOP_INST = 32'h0000_0000;
    localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with hold and flush.
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               load a bubble; overrides hold
//   hold                keep current contents
//   load                pc_d/inst_d carry a real instruction this cycle
//   pc_d, inst_d        incoming PC+4 and instruction word
//   pc_q, inst_q, valid_q  registered IF/ID contents
module if_id_reg
    import fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              hold,
    input  logic              load,
    input  logic [WORD_W-1:0] pc_d,
    input  logic [WORD_W-1:0] inst_d,
    output logic [WORD_W-1:0] pc_q,
    output logic [WORD_W-1:0] inst_q,
    output logic              valid_q
);
    logic take;

    assign take = load & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
        end else if (flush || !hold) begin
            pc_q    <= take ? pc_d : '0;
            inst_q  <= take ? inst_d : NOP_INST;
            valid_q <= take;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS IF stage -- owns the PC, runs the imem handshake, feeds IF/ID.
//   clk_i, rst_i             clock, asynchronous active-low reset
//   start_i                  fetch enable, sampled only in IDLE
//   pc_stall_i, stall_hold_i load-use stall from hazard detection
//   redirect_i, redirect_pc_i taken branch/jump from ID and its target
//   imem_req_o, imem_addr_o  instruction-memory request and address
//   imem_ready_i, imem_data_i memory response
//   pc_o                     next-fetch PC
//   if_id_pc_o, if_id_inst_o, if_id_valid_o  IF/ID register contents
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              pc_stall_i,
    input  logic              stall_hold_i,
    input  logic              redirect_i,
    input  logic [WORD_W-1:0] redirect_pc_i,
    output logic              imem_req_o,
    output logic [WORD_W-1:0] imem_addr_o,
    input  logic              imem_ready_i,
    input  logic [WORD_W-1:0] imem_data_i,
    output logic [WORD_W-1:0] pc_o,
    output logic [WORD_W-1:0] if_id_pc_o,
    output logic [WORD_W-1:0] if_id_inst_o,
    output logic              if_id_valid_o
);
    state_t            state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d, addr_q, addr_d, buf_q, buf_d;
    logic [WORD_W-1:0] target, pc_inc, load_inst;
    logic              stall, load;

    assign stall       = pc_stall_i | stall_hold_i;
    assign target      = {redirect_pc_i[WORD_W-1:2], 2'b00};
    assign pc_inc      = pc_q + 32'd4;
    // Request stays up in DROP: an issued request is never aborted.
    assign imem_req_o  = (state_q == REQ) || (state_q == DROP);
    assign imem_addr_o = addr_q;
    assign pc_o        = pc_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            buf_q   <= NOP_INST;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        buf_d     = buf_q;
        load      = 1'b0;
        load_inst = imem_data_i;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = REQ;
                    addr_d  = pc_q;
                end
            end
            REQ: begin
                if (imem_ready_i) begin
                    if (redirect_i) begin
                        pc_d   = target;
                        addr_d = target;
                    end else if (stall) begin
                        buf_d   = imem_data_i;
                        state_d = HOLD;
                    end else begin
                        load   = 1'b1;
                        pc_d   = pc_inc;
                        addr_d = pc_inc;
                    end
                end else if (redirect_i) begin
                    pc_d    = target;
                    state_d = DROP;
                end
            end
            HOLD: begin
                if (redirect_i) begin
                    pc_d    = target;
                    addr_d  = target;
                    state_d = REQ;
                end else if (!stall) begin
                    load      = 1'b1;
                    load_inst = buf_q;
                    pc_d      = pc_inc;
                    addr_d    = pc_inc;
                    state_d   = REQ;
                end
            end
            DROP: begin
                if (redirect_i) pc_d = target;
                // Stale word is thrown away; next request goes to the newest target.
                if (imem_ready_i) begin
                    addr_d  = redirect_i ? target : pc_q;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    if_id_reg u_if_id (
        .clk     (clk_i),
        .rst_n   (rst_i),
        .flush   (redirect_i),
        .hold    (stall),
        .load    (load),
        .pc_d    (pc_inc),
        .inst_d  (load_inst),
        .pc_q    (if_id_pc_o),
        .inst_q  (if_id_inst_o),
        .valid_q (if_id_valid_o)
    );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized self-checking bench for fetch_stage.
module tb_fetch_stage;
    import fetch_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic        pc_stall_i = 1'b0;
    logic        stall_hold_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_ready_i = 1'b0;
    logic [31:0] imem_data_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] pc_o;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_inst_o;
    logic        if_id_valid_o;

    fetch_stage dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .pc_stall_i    (pc_stall_i),
        .stall_hold_i  (stall_hold_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ready_i  (imem_ready_i),
        .imem_data_i   (imem_data_i),
        .pc_o          (pc_o),
        .if_id_pc_o    (if_id_pc_o),
        .if_id_inst_o  (if_id_inst_o),
        .if_id_valid_o (if_id_valid_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model: fetch engine described by three flags rather than states.
    bit          running, stale, buffered;
    logic [31:0] m_pc, m_addr, m_buf;
    logic [31:0] e_pc, e_inst;
    bit          e_valid;
    // Memory model and stimulus knobs.
    int          lat, waited, lat_lo, lat_hi;
    int          p_start, p_stall, p_redir;
    logic [31:0] salt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_req();
        return running && !buffered;
    endfunction

    task automatic model_reset();
        running  = 0;
        stale    = 0;
        buffered = 0;
        m_pc     = RESET_PC_DEFAULT;
        m_addr   = RESET_PC_DEFAULT;
        m_buf    = '0;
        e_pc     = '0;
        e_inst   = NOP_INST;
        e_valid  = 0;
        waited   = 0;
        lat      = lat_lo;
    endtask

    task automatic check_all();
        check("req", {31'd0, imem_req_o}, {31'd0, m_req()});
        if (m_req()) check("addr", imem_addr_o, m_addr);
        check("pc", pc_o, m_pc);
        check("valid", {31'd0, if_id_valid_o}, {31'd0, e_valid});
        check("inst", if_id_inst_o, e_inst);
        if (e_valid) check("if_id_pc", if_id_pc_o, e_pc);
    endtask

    task automatic drive();
        int  s;
        logic sd;
        start_i       = int'($urandom_range(0, 99)) < p_start;
        sd            = int'($urandom_range(0, 99)) < p_stall;
        s             = int'($urandom_range(0, 2));
        pc_stall_i    = sd && s != 1;
        stall_hold_i  = sd && s != 0;
        redirect_i    = int'($urandom_range(0, 99)) < p_redir;
        redirect_pc_i = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF8 | $urandom_range(0, 7)) : $urandom;
        imem_ready_i  = m_req() && waited >= lat;
        imem_data_i   = imem_ready_i ? (m_addr ^ salt) : $urandom;
    endtask

    task automatic model_update();
        logic        r, st, rd, have;
        logic [31:0] t, nxt, w;
        r    = m_req();
        st   = pc_stall_i | stall_hold_i;
        rd   = redirect_i;
        t    = redirect_pc_i & 32'hFFFF_FFFC;
        nxt  = m_pc + 32'd4;
        have = 0;
        w    = NOP_INST;
        if (buffered && !st && !rd) begin
            have = 1;
            w    = m_buf;
        end
        if (r && !stale && imem_ready_i && !st && !rd) begin
            have = 1;
            w    = imem_data_i;
        end
        if (rd || (!st && !have)) begin
            e_pc    = '0;
            e_inst  = NOP_INST;
            e_valid = 0;
        end else if (!st) begin
            e_pc    = nxt;
            e_inst  = w;
            e_valid = 1;
        end
        if (!running) begin
            if (start_i) begin
                running = 1;
                m_addr  = m_pc;
            end
        end else if (buffered) begin
            if (rd) begin
                m_pc = t; m_addr = t; buffered = 0;
            end else if (!st) begin
                m_pc = nxt; m_addr = nxt; buffered = 0;
            end
        end else if (stale) begin
            if (rd) m_pc = t;
            if (imem_ready_i) begin
                m_addr = m_pc;
                stale  = 0;
            end
        end else if (imem_ready_i) begin
            if (rd) begin
                m_pc = t; m_addr = t;
            end else if (st) begin
                m_buf = imem_data_i; buffered = 1;
            end else begin
                m_pc = nxt; m_addr = nxt;
            end
        end else if (rd) begin
            m_pc  = t;
            stale = 1;
        end
        if (imem_ready_i) begin
            waited = 0;
            lat    = int'($urandom_range(lat_lo, lat_hi));
        end else if (r) begin
            waited++;
        end
    endtask

    task automatic step();
        drive();
        @(posedge clk_i);
        model_update();
        #1;
        check_all();
    endtask

    task automatic knobs(input int ps, input int pst, input int prd, input int llo, input int lhi);
        p_start = ps;
        p_stall = pst;
        p_redir = prd;
        lat_lo  = llo;
        lat_hi  = lhi;
        lat     = llo;
    endtask

    initial begin
        salt = '0;
        knobs(100, 0, 0, 0, 0);
        model_reset();
        #1;
        check("rst_if_id_pc", if_id_pc_o, 32'd0);
        check_all();
        @(negedge clk_i);
        rst_i = 1'b1;

        // Zero-wait memory returning the address as data.
        step();
        step();
        check("zw0_pc", if_id_pc_o, 32'd4);
        check("zw0_inst", if_id_inst_o, 32'd0);
        step();
        check("zw1_pc", if_id_pc_o, 32'd8);
        check("zw1_inst", if_id_inst_o, 32'd4);
        step();
        check("zw2_pc", if_id_pc_o, 32'd12);
        check("zw2_inst", if_id_inst_o, 32'd8);
        check("zw2_valid", {31'd0, if_id_valid_o}, 32'd1);
        repeat (20) step();

        // Three-cycle memory.
        knobs(100, 0, 0, 2, 2);
        repeat (24) step();

        // Mixed latency, stalls and redirects.
        salt = $urandom;
        knobs(50, 25, 15, 0, 3);
        repeat (1500) step();
        knobs(50, 60, 30, 0, 4);
        repeat (800) step();

        // Reset in the middle of a DROP.
        @(negedge clk_i);
        rst_i = 1'b0;
        salt  = '0;
        knobs(100, 0, 0, 10, 10);
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        step();
        step();
        knobs(100, 0, 100, 10, 10);
        step();
        check("drop_req", {31'd0, imem_req_o}, 32'd1);
        knobs(100, 0, 0, 10, 10);
        step();
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("async_req", {31'd0, imem_req_o}, 32'd0);
        check("async_pc", pc_o, RESET_PC_DEFAULT);
        check("async_valid", {31'd0, if_id_valid_o}, 32'd0);
        check("async_inst", if_id_inst_o, NOP_INST);
        check("async_if_id_pc", if_id_pc_o, 32'd0);
        knobs(100, 0, 0, 0, 0);
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        step();
        check("resume_addr", imem_addr_o, RESET_PC_DEFAULT);
        step();
        check("resume_pc", if_id_pc_o, 32'd4);
        check("resume_inst", if_id_inst_o, 32'd0);
        repeat (10) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
